timer_counter_n: RTL

- Parametrised N-bit up/down timer counter; next generation of the fixed 8-bit timer counter.
- Adds configurable width, an optional auto-reload on wrap, a compare-match flag, and a readable count value.
- Counts only on cycles where the externally generated prescaler strobe `clk_ena` is high.
- Sits between the clock-select/prescaler block and the register/interrupt logic of the timer subsystem.

---
 rtl/timer_pkg.sv | 19 +
 rtl/timer_sticky_flag.sv | 21 ++
 rtl/timer_counter_n.sv | 106 ++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer subsystem: flag bit positions, default
// counter geometry and a helper that yields the all-ones count for a width.
package timer_pkg;

  // Bit positions of the three status flags, shared with the register block.
  localparam int FLG_OVF = 0;
  localparam int FLG_UDF = 1;
  localparam int FLG_CMP = 2;

  // Default geometry shared by the prescaler, counter and register blocks.
  localparam int TIMER_WIDTH_DEF   = 8;
  localparam int TIMER_RST_VAL_DEF = 0;

  // Largest unsigned value representable in `width` bits (width 1..32).
  function automatic logic [31:0] MAX_CNT(input int unsigned width);
    return 32'hFFFF_FFFF >> (32 - width);
  endfunction

endpackage

// File: rtl/timer_sticky_flag.sv
// Sticky status flag: set has priority over clear so that an event arriving
// on the same edge as a software clear is never lost.
module timer_sticky_flag (
  input  logic clk,
  input  logic rst_n,
  input  logic set,
  input  logic clr,
  output logic flag
);

  // Hold the flag until cleared; a simultaneous set keeps it high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      flag <= 1'b0;
    else if (set)
      flag <= 1'b1;
    else if (clr)
      flag <= 1'b0;
  end

endmodule

// File: rtl/timer_counter_n.sv
// Parametrised N-bit up/down timer counter with optional auto-reload on wrap,
// sticky overflow/underflow/compare flags and a readable count value.
// Optional interrupt output is built when TIMER_COUNTER_IRQ_EN is defined.
module timer_counter_n
  import timer_pkg::*;
#(
  parameter int              WIDTH   = TIMER_WIDTH_DEF,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(TIMER_RST_VAL_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_ena,
  input  logic [WIDTH-1:0] start_counter,
  input  logic [WIDTH-1:0] compare_val,
  input  logic             up_down,
  input  logic             load,
  input  logic             enable,
  input  logic             auto_reload,
  input  logic             clr_overflow,
  input  logic             clr_underflow,
  input  logic             clr_compare,
  output logic [WIDTH-1:0] cnt_value,
  output logic             overflow,
  output logic             underflow,
  output logic             compare_match
`ifdef TIMER_COUNTER_IRQ_EN
  ,
  input  logic [2:0]       irq_mask,
  output logic             irq
`endif
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX_CNT(WIDTH));

  logic [WIDTH-1:0] reg_TCNT;
  logic [WIDTH-1:0] next_cnt;
  logic             step;
  logic [2:0]       flag_set;
  logic [2:0]       flag_clr;
  logic [2:0]       flags;

  // Next-count selection: load beats counting, wraps go to reload or the far end.
  always_comb begin
    next_cnt = reg_TCNT;
    flag_set = 3'b000;
    step     = enable & clk_ena & ~load;
    if (load) begin
      next_cnt = start_counter;
    end else if (step) begin
      if (up_down) begin
        if (reg_TCNT == MAX_VAL) begin
          next_cnt          = auto_reload ? start_counter : '0;
          flag_set[FLG_OVF] = 1'b1;
        end else begin
          next_cnt = reg_TCNT + 1'b1;
        end
      end else begin
        if (reg_TCNT == '0) begin
          next_cnt          = auto_reload ? start_counter : MAX_VAL;
          flag_set[FLG_UDF] = 1'b1;
        end else begin
          next_cnt = reg_TCNT - 1'b1;
        end
      end
      flag_set[FLG_CMP] = (next_cnt == compare_val);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      reg_TCNT <= RST_VAL;
    else
      reg_TCNT <= next_cnt;
  end

  assign flag_clr[FLG_OVF] = clr_overflow;
  assign flag_clr[FLG_UDF] = clr_underflow;
  assign flag_clr[FLG_CMP] = clr_compare;

  for (genvar g = 0; g < 3; g++) begin : g_flag
    timer_sticky_flag u_flag (
      .clk   (clk),
      .rst_n (rst_n),
      .set   (flag_set[g]),
      .clr   (flag_clr[g]),
      .flag  (flags[g])
    );
  end

  assign cnt_value     = reg_TCNT;
  assign overflow      = flags[FLG_OVF];
  assign underflow     = flags[FLG_UDF];
  assign compare_match = flags[FLG_CMP];

`ifdef TIMER_COUNTER_IRQ_EN
  // Registered interrupt: any unmasked flag raises irq one clock later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      irq <= 1'b0;
    else
      irq <= |(irq_mask & flags);
  end
`endif

endmodule
